// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that owns the PC and keeps one memory request in flight.
// Ports: clk_in/rst_in (async active-low) clock and reset; stall_in IF/ID hold;
// redirect_in/redirect_pc_in branch/jump/flush target; imem_req_out/imem_addr_out/
// imem_gnt_in request channel; imem_rvalid_in/imem_rdata_in response channel;
// pc_out/instr_out/valid_out presented instruction buffer.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(32'h0000_0013)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, opc_q, opc_d, oin_q, oin_d;
  logic             oval_q, oval_d;
  logic             acc;
  // A request only goes out when the buffer is empty or being taken this edge,
  // so a response can never land on an unconsumed instruction.
  assign imem_req_out  = rst_in && state_q == S_REQ && (!oval_q || !stall_in);
  assign imem_addr_out = pc_q;
  assign acc           = imem_req_out && imem_gnt_in;
  assign pc_out        = opc_q;
  assign instr_out     = oin_q;
  assign valid_out     = oval_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    oin_d   = oin_q;
    oval_d  = oval_q;
    if (oval_q && !stall_in) begin
      oval_d = 1'b0;
      oin_d  = NOP;
    end
    case (state_q)
      S_REQ:  state_d = acc ? S_WAIT : S_REQ;
      S_WAIT: if (imem_rvalid_in) begin
        state_d = S_REQ;
        pc_d    = pc_q + WIDTH'(4);
        opc_d   = pc_q;
        oin_d   = imem_rdata_in;
        oval_d  = 1'b1;
      end
      S_DROP: state_d = imem_rvalid_in ? S_REQ : S_DROP;
      default: state_d = S_REQ;
    endcase
    // Redirect overrides everything; a request already accepted must have its
    // response swallowed, hence DROP unless that response arrives right now.
    if (redirect_in) begin
      pc_d    = redirect_pc_in & ~WIDTH'(3);
      opc_d   = '0;
      oin_d   = NOP;
      oval_d  = 1'b0;
      state_d = state_q == S_REQ ? (acc ? S_DROP : S_REQ) : (imem_rvalid_in ? S_REQ : S_DROP);
    end
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      oin_q   <= NOP;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      oin_q   <= oin_d;
      oval_q  <= oval_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-order model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013, KEY = 32'hA5A5_0000;
  logic        clk_in = 0, rst_in = 1, stall_in = 0, redirect_in = 0, imem_gnt_in = 0, imem_rvalid_in = 0;
  logic [31:0] redirect_pc_in = 0, imem_rdata_in = 0;
  logic        imem_req_out, valid_out;
  logic [31:0] imem_addr_out, pc_out, instr_out;
  fetch_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out)
  );
  always #5 clk_in = ~clk_in;
  int          vectors = 0, miscompares = 0;
  logic        stall = 0, redir = 0;
  logic [31:0] rpc = 0;
  int          gmode = 0, lat = 0;
  bit          rnd_lat = 0;
  bit          pend = 0;
  logic [31:0] paddr = 0;
  int          cnt = 0, reqcnt = 0, consumed = 0;
  logic [31:0] exp_pc = 0;
  bit          prev_redir = 0;
  logic        s_req, s_gnt, s_rv, s_val, s_stall, s_redir;
  logic [31:0] s_addr, s_rpc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Drive one cycle of inputs at the falling edge, then sample and check the
  // program-order rules: a valid buffer must hold the next instruction in order.
  task automatic drive();
    @(negedge clk_in);
    stall_in       = stall;
    redirect_in    = redir;
    redirect_pc_in = rpc;
    imem_rvalid_in = pend && cnt == 0;
    imem_rdata_in  = imem_rvalid_in ? paddr ^ KEY : $urandom;
    imem_gnt_in    = gmode == 0 ? 1'b1 : gmode == 1 ? (reqcnt >= 3) : ($urandom_range(0, 9) < 6);
    #1;
    s_req = imem_req_out; s_gnt = imem_gnt_in; s_rv = imem_rvalid_in; s_val = valid_out;
    s_stall = stall_in; s_redir = redirect_in; s_addr = imem_addr_out; s_rpc = redirect_pc_in;
    if (valid_out) begin
      chk("pc", pc_out, exp_pc);
      chk("instr", instr_out, exp_pc ^ KEY);
    end else chk("bubble", instr_out, NOP);
    if (prev_redir) begin
      chk("redir_valid", 32'(valid_out), 0);
      chk("redir_pc", pc_out, 0);
    end
    if (valid_out && stall_in) chk("full_guard", 32'(imem_req_out), 0);
    if (imem_req_out) begin
      chk("outstanding", 32'(pend), 0);
      chk("align", 32'(imem_addr_out[1:0]), 0);
    end
  endtask
  task automatic fin();
    @(posedge clk_in);
    if (s_rv) pend = 0;
    else if (pend && cnt > 0) cnt--;
    if (s_req && s_gnt) begin
      pend  = 1;
      paddr = s_addr;
      cnt   = rnd_lat ? int'($urandom_range(0, 3)) : lat;
    end
    reqcnt = (s_req && !s_gnt) ? reqcnt + 1 : 0;
    if (s_val && !s_stall && !s_redir) begin
      exp_pc += 4;
      consumed++;
    end
    if (s_redir) exp_pc = s_rpc & ~32'd3;
    prev_redir = s_redir;
  endtask
  task automatic step();
    drive();
    fin();
  endtask
  task automatic wait_valid(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      drive();
      if (valid_out) break;
      fin();
    end
    if (i == bound) chk("timeout_valid", 32'(valid_out), 1);
  endtask
  initial begin
    int          nreq;
    bit          done;
    logic [31:0] wrap_exp [3];
    wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    #1 rst_in = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_req", 32'(imem_req_out), 0);
    chk("rst_addr", imem_addr_out, 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 0);
    @(posedge clk_in);
    #2 rst_in = 1;
    for (int k = 1; k <= 6; k++) begin
      drive();
      chk("lin_valid", 32'(valid_out), 32'(k >= 3 && k % 2 == 1));
      chk("lin_req", 32'(imem_req_out), 32'(k % 2));
      if (k == 1) chk("first_addr", imem_addr_out, 0);
      fin();
    end
    stall = 1;
    for (int k = 7; k <= 11; k++) begin
      drive();
      chk("hold_valid", 32'(valid_out), 1);
      chk("hold_pc", pc_out, 32'h8);
      chk("hold_instr", instr_out, 32'h8 ^ KEY);
      chk("hold_req", 32'(imem_req_out), 0);
      fin();
    end
    stall = 0; gmode = 1; lat = 3; nreq = 0;
    for (int k = 0; k < 10; k++) begin
      drive();
      if (imem_req_out) begin
        nreq++;
        chk("slow_addr", imem_addr_out, 32'hC);
      end
      done = imem_req_out && imem_gnt_in;
      fin();
      if (done) break;
    end
    chk("slow_reqs", nreq, 4);
    gmode = 0; lat = 4;
    wait_valid(12);
    chk("slow_pc", pc_out, 32'hC);
    chk("slow_instr", instr_out, 32'hC ^ KEY);
    fin();
    redir = 1; rpc = 32'h103;
    step();
    redir = 0;
    for (int k = 0; k < 10; k++) begin
      drive();
      chk("drop_valid", 32'(valid_out), 0);
      if (imem_req_out) break;
      fin();
    end
    chk("drop_addr", imem_addr_out, 32'h100);
    fin();
    wait_valid(12);
    chk("drop_pc", pc_out, 32'h100);
    fin();
    lat = 0; stall = 1;
    wait_valid(12);
    fin();
    stall = 0; redir = 1; rpc = 32'h200;
    drive();
    chk("simg_req", 32'(imem_req_out), 1);
    fin();
    redir = 0;
    drive();
    chk("simg_valid", 32'(valid_out), 0);
    chk("simg_drop", 32'(imem_req_out), 0);
    fin();
    lat = 2;
    drive();
    chk("simg_addr", imem_addr_out, 32'h200);
    fin();
    rpc = 32'h300;
    for (int k = 0; k < 10; k++) begin
      redir = pend && cnt == 0;
      step();
      if (redir) break;
    end
    redir = 0;
    drive();
    chk("simr_req", 32'(imem_req_out), 1);
    chk("simr_addr", imem_addr_out, 32'h300);
    fin();
    stall = 1;
    wait_valid(12);
    fin();
    redir = 1; rpc = 32'hFFFF_FFFA;
    step();
    redir = 0;
    drive();
    chk("stl_valid", 32'(valid_out), 0);
    chk("stl_instr", instr_out, NOP);
    fin();
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(12);
      chk("wrap_pc", pc_out, wrap_exp[k]);
      fin();
    end
    lat = 5;
    wait_valid(12);
    fin();
    drive();
    #2 rst_in = 0;
    #1;
    chk("arst_pc", pc_out, 0);
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_instr", instr_out, NOP);
    chk("arst_req", 32'(imem_req_out), 0);
    chk("arst_addr", imem_addr_out, 0);
    @(posedge clk_in);
    pend = 0; exp_pc = 0; prev_redir = 0; reqcnt = 0;
    #2 rst_in = 1;
    lat = 0;
    wait_valid(12);
    chk("arst_refetch", pc_out, 0);
    fin();
    consumed = 0; gmode = 2; rnd_lat = 1;
    for (int k = 0; k < 3000; k++) begin
      stall = $urandom_range(0, 9) < 3;
      redir = $urandom_range(0, 19) == 0;
      rpc   = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      step();
    end
    redir = 0; stall = 0;
    repeat (10) step();
    chk("progress", 32'(consumed > 100), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
